clock_set_ctrl: RTL
===================

// Module: clock_set_ctrl
// PURPOSE
//  Time-setting controller for the 7-segment clock. Consumes the debounced MODE and INC button levels,
//  turns them into press events with hold-to-repeat, and sequences RUN -> SET_HR -> SET_MIN -> RUN.
//  Drives one-cycle increment/clear strobes into the timekeeping counters and a blink enable to the display mux.
// PARAMETERS
//  CNT_W        17      width of internal hold/repeat/timeout/blink counters
//  HOLD_TICKS   6250    cycles INC must be held before first auto-repeat (0.5 s at 12.5 kHz)
//  REPEAT_TICKS 2500    cycles between auto-repeat strobes (0.2 s)
//  TIMEOUT_TICKS 125000 idle cycles in a SET state before returning to RUN (10 s)
//  BLINK_TICKS  3125    half-period of o_blink in SET states (0.25 s)
// PORTS
//  i_clk        in  1  system clock (12.5 kHz)
//  i_rst        in  1  synchronous reset, active-high
//  i_mode_db    in  1  debounced MODE button level, 1 = pressed
//  i_inc_db     in  1  debounced INC button level, 1 = pressed
//  o_mode       out 2  00 RUN, 01 SET_HR, 10 SET_MIN (11 never driven)
//  o_inc_hr     out 1  one-cycle strobe: increment hours
//  o_inc_min    out 1  one-cycle strobe: increment minutes
//  o_clr_sec    out 1  one-cycle strobe: zero seconds on leaving SET_MIN via MODE
//  o_blink      out 1  1 = digits on; toggles in SET states, constant 1 in RUN
// BEHAVIOUR
//  - One clock i_clk; reset synchronous active-high. Reset: o_mode=RUN, all strobes 0, o_blink=1, counters 0.
//  - Edge detect: prev-level regs load the current inputs every cycle incl. during reset; button held through
//    reset produces no event. Press event = input 1 and prev 0.
//  - All outputs registered: strobe/state change appears on the clock edge after the sampling edge where the
//    press event is detected (latency 1 cycle); strobes high exactly one cycle.
//  - FSM on MODE press: RUN->SET_HR; SET_HR->SET_MIN; SET_MIN->RUN with o_clr_sec pulse in the same cycle.
//  - INC press in SET_HR -> o_inc_hr; in SET_MIN -> o_inc_min; in RUN ignored (no strobe, no counting).
//  - Auto-repeat (SET states only): hold counter clears on INC press, counts while INC=1. First repeat strobe when
//    count reaches HOLD_TICKS-1 after press; thereafter every REPEAT_TICKS cycles while held. Release stops at once.
//  - MODE press and INC press in the same cycle: MODE wins, no inc strobe; repeat disarmed until INC released
//    and pressed again. Mode change while INC held also disarms repeat.
//  - Timeout (SET states): idle counter clears on any press event and every cycle INC=1; reaching
//    TIMEOUT_TICKS-1 -> RUN without o_clr_sec. Counter held at 0 in RUN.
//  - Blink: entering a SET state sets o_blink=1 and clears blink counter; toggles every BLINK_TICKS cycles;
//    forced 1 in RUN. Any inc strobe re-forces o_blink=1 and restarts its counter (digit visible while adjusting).
//  - Counters saturate/compare at CNT_W bits; params must be < 2^CNT_W (elaboration-time check).
//  - Reset mid-setting: immediate return to RUN, no strobes issued in reset cycle or the cycle after.
// TESTING  (bench params: HOLD=8, REPEAT=4, TIMEOUT=50, BLINK=5)
//  1 Reset with i_inc_db=1 held, release rst -> no o_inc_* strobe; o_mode=00, o_blink=1.
//  2 Three MODE presses (2-cycle pulses) -> o_mode 01,10,00; o_clr_sec single pulse with third transition.
//  3 SET_HR, hold INC 20 cycles -> o_inc_hr at press+1, then at press+8, +12, +16, +20 count; none after release.
//  4 SET_MIN, MODE and INC rise same cycle -> o_mode=00, o_clr_sec=1, no o_inc_min even with INC held 30 cycles.
//  5 SET_HR, no input 50 cycles -> o_mode=00 at cycle 50, o_clr_sec stays 0; o_blink toggled every 5 cycles, then 1.
//  6 SET_MIN, assert i_rst mid-repeat -> next cycle o_mode=00, strobes 0; INC still held gives no event post-reset.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// Time-setting controller for the 7-segment clock: MODE/INC press detection, hold-to-repeat,
// RUN -> SET_HR -> SET_MIN -> RUN sequencing, idle timeout and digit blink.
module clock_set_ctrl #(
    parameter int CNT_W         = 17,
    parameter int HOLD_TICKS    = 6250,
    parameter int REPEAT_TICKS  = 2500,
    parameter int TIMEOUT_TICKS = 125000,
    parameter int BLINK_TICKS   = 3125
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_mode_db,
    input  logic       i_inc_db,
    output logic [1:0] o_mode,
    output logic       o_inc_hr,
    output logic       o_inc_min,
    output logic       o_clr_sec,
    output logic       o_blink
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_SET_HR  = 2'b01,
        ST_SET_MIN = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_V     = CNT_W'(REPEAT_TICKS);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_TICKS - 1);
    localparam logic [CNT_W-1:0] BLINK_V      = CNT_W'(BLINK_TICKS);

    if ((longint'(HOLD_TICKS) >= (longint'(1) << CNT_W)) ||
        (longint'(REPEAT_TICKS) >= (longint'(1) << CNT_W)) ||
        (longint'(TIMEOUT_TICKS) >= (longint'(1) << CNT_W)) ||
        (longint'(BLINK_TICKS) >= (longint'(1) << CNT_W))) begin : g_param_check
        $error("clock_set_ctrl: tick parameter does not fit in CNT_W bits");
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    state_t           state_r;
    logic             mode_prev_r;
    logic             inc_prev_r;
    logic             armed_r;
    logic             rep_phase_r;
    logic [CNT_W-1:0] hold_cnt_r;
    logic [CNT_W-1:0] idle_cnt_r;
    logic [CNT_W-1:0] blink_cnt_r;

    logic             mode_ev_s;
    logic             inc_ev_s;
    logic             in_set_s;
    logic             repeat_fire_s;
    logic [CNT_W-1:0] hold_inc_s;
    logic [CNT_W-1:0] idle_inc_s;
    logic [CNT_W-1:0] blink_inc_s;

    assign o_mode = state_r;

    // Press events, next counter values and the auto-repeat fire condition.
    always_comb begin
        mode_ev_s   = i_mode_db & ~mode_prev_r;
        inc_ev_s    = i_inc_db & ~inc_prev_r;
        in_set_s    = (state_r != ST_RUN);
        hold_inc_s  = sat_inc(hold_cnt_r);
        idle_inc_s  = sat_inc(idle_cnt_r);
        blink_inc_s = sat_inc(blink_cnt_r);
        if (in_set_s && armed_r && i_inc_db && !mode_ev_s) begin
            if (rep_phase_r) begin
                repeat_fire_s = (hold_inc_s == REPEAT_V);
            end else begin
                repeat_fire_s = (hold_inc_s == HOLD_LAST);
            end
        end else begin
            repeat_fire_s = 1'b0;
        end
    end

    // Mode FSM, strobes, repeat/timeout/blink counters; prev levels track inputs even in reset.
    always_ff @(posedge i_clk) begin
        mode_prev_r <= i_mode_db;
        inc_prev_r  <= i_inc_db;
        if (i_rst) begin
            state_r     <= ST_RUN;
            o_inc_hr    <= 1'b0;
            o_inc_min   <= 1'b0;
            o_clr_sec   <= 1'b0;
            o_blink     <= 1'b1;
            armed_r     <= 1'b0;
            rep_phase_r <= 1'b0;
            hold_cnt_r  <= '0;
            idle_cnt_r  <= '0;
            blink_cnt_r <= '0;
        end else begin
            o_inc_hr  <= 1'b0;
            o_inc_min <= 1'b0;
            o_clr_sec <= 1'b0;
            if (mode_ev_s) begin
                // MODE beats a simultaneous INC press and disarms repeat until INC is re-pressed.
                case (state_r)
                    ST_RUN:     state_r <= ST_SET_HR;
                    ST_SET_HR:  state_r <= ST_SET_MIN;
                    ST_SET_MIN: begin
                        state_r   <= ST_RUN;
                        o_clr_sec <= 1'b1;
                    end
                    default:    state_r <= ST_RUN;
                endcase
                armed_r     <= 1'b0;
                rep_phase_r <= 1'b0;
                hold_cnt_r  <= '0;
                idle_cnt_r  <= '0;
                blink_cnt_r <= '0;
                o_blink     <= 1'b1;
            end else if (!in_set_s) begin
                armed_r     <= 1'b0;
                rep_phase_r <= 1'b0;
                hold_cnt_r  <= '0;
                idle_cnt_r  <= '0;
                blink_cnt_r <= '0;
                o_blink     <= 1'b1;
            end else if (!i_inc_db && (idle_inc_s == TIMEOUT_LAST)) begin
                state_r     <= ST_RUN;
                armed_r     <= 1'b0;
                rep_phase_r <= 1'b0;
                hold_cnt_r  <= '0;
                idle_cnt_r  <= '0;
                blink_cnt_r <= '0;
                o_blink     <= 1'b1;
            end else if (inc_ev_s || repeat_fire_s) begin
                o_inc_hr    <= (state_r == ST_SET_HR);
                o_inc_min   <= (state_r == ST_SET_MIN);
                armed_r     <= 1'b1;
                rep_phase_r <= repeat_fire_s;
                hold_cnt_r  <= '0;
                idle_cnt_r  <= '0;
                blink_cnt_r <= '0;
                o_blink     <= 1'b1;
            end else begin
                armed_r     <= armed_r & i_inc_db;
                rep_phase_r <= rep_phase_r & i_inc_db;
                if (armed_r && i_inc_db) begin
                    hold_cnt_r <= hold_inc_s;
                end else begin
                    hold_cnt_r <= '0;
                end
                if (i_inc_db) begin
                    idle_cnt_r <= '0;
                end else begin
                    idle_cnt_r <= idle_inc_s;
                end
                if (blink_inc_s == BLINK_V) begin
                    blink_cnt_r <= '0;
                    o_blink     <= ~o_blink;
                end else begin
                    blink_cnt_r <= blink_inc_s;
                end
            end
        end
    end

endmodule
